// File: rtl/datapath_ctrl_fsm.sv
// Multicycle Moore controller sequencing the 16-bit datapath for one decoded instruction per start.
// Optional illegal-opcode trap (HALT state) enabled by defining CTRL_ILLEGAL_TRAP_EN.
module datapath_ctrl_fsm #(
  parameter bit START_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       illegal
);

  typedef enum logic [3:0] {
    ST_WAIT,
    ST_DECODE,
    ST_GET_A,
    ST_GET_B,
    ST_EXEC,
    ST_EXEC_CMP,
    ST_WRITE_REG,
    ST_WRITE_IMM
`ifdef CTRL_ILLEGAL_TRAP_EN
    , ST_HALT
`endif
  } state_t;

  state_t state_reg, state_next;
  logic   armed_reg;
  logic   zero_a_reg;   // MOV-reg / MVN: ALU A input forced to zero in EXEC
  logic   cmp_path_reg; // CMP: GET_B continues to EXEC_CMP instead of EXEC

  logic is_mov_imm, is_mov_reg, is_alu2, is_cmp, is_mvn;

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu2    = (opcode == 3'b101) && ((op == 2'b00) || (op == 2'b10));
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);

  // State register plus the flags captured alongside it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_WAIT;
      armed_reg    <= 1'b1;
      zero_a_reg   <= 1'b0;
      cmp_path_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_WAIT) begin
        if (!s)
          armed_reg <= 1'b1;
        else if (state_next == ST_DECODE)
          armed_reg <= 1'b0;
      end
      if (state_reg == ST_DECODE) begin
        zero_a_reg   <= is_mov_reg || is_mvn;
        cmp_path_reg <= is_cmp;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT: begin
        if (s && (!START_LEVEL || armed_reg))
          state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_mov_imm)
          state_next = ST_WRITE_IMM;
        else if (is_mov_reg || is_mvn)
          state_next = ST_GET_B;
        else if (is_alu2 || is_cmp)
          state_next = ST_GET_A;
        else
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_next = ST_HALT;
`else
          state_next = ST_WAIT;
`endif
      end
      ST_GET_A:     state_next = ST_GET_B;
      ST_GET_B:     state_next = cmp_path_reg ? ST_EXEC_CMP : ST_EXEC;
      ST_EXEC:      state_next = ST_WRITE_REG;
      ST_EXEC_CMP:  state_next = ST_WAIT;
      ST_WRITE_REG: state_next = ST_WAIT;
      ST_WRITE_IMM: state_next = ST_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_HALT:      state_next = ST_HALT;
`endif
      default:      state_next = ST_WAIT;
    endcase
  end

  // Moore output decode
  always_comb begin
    w       = 1'b0;
    nsel    = 3'b000;
    vsel    = 2'b00;
    write   = 1'b0;
    loada   = 1'b0;
    loadb   = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    illegal = 1'b0;
    case (state_reg)
      ST_WAIT:   w = 1'b1;
      ST_DECODE: ;
      ST_GET_A: begin
        nsel  = 3'b001;
        loada = 1'b1;
      end
      ST_GET_B: begin
        nsel  = 3'b100;
        loadb = 1'b1;
      end
      ST_EXEC: begin
        loadc = 1'b1;
        asel  = zero_a_reg;
      end
      ST_EXEC_CMP: loads = 1'b1;
      ST_WRITE_REG: begin
        nsel  = 3'b010;
        vsel  = 2'b00;
        write = 1'b1;
      end
      ST_WRITE_IMM: begin
        nsel  = 3'b001;
        vsel  = 2'b10;
        write = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_HALT: illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/datapath_ctrl_fsm.md
Name: datapath_ctrl_fsm

Overview:
- Multicycle Moore controller that sequences the 16-bit datapath (register file, A/B/C/status registers, shifter, ALU) for one decoded instruction per start request.
- Takes opcode/op fields from the instruction decoder.
- Drives register-select, write-back mux, load enables and operand-mux selects.
- Returns to an idle state that asserts w; sits between the instruction register/decoder and the datapath.

Parameters:
- START_LEVEL, 0: 0 = start accepted whenever s=1 in WAIT; 1 = s must be seen low in WAIT after each completion before the next start is accepted (edge semantics).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- s  in  1  start request
- opcode  in  3  instruction bits [15:13]
- op  in  2  instruction bits [12:11]
- w  out  1  idle/ready, high only in WAIT
- nsel  out  3  one-hot register select to decoder: 001 Rn, 010 Rd, 100 Rm, 000 none
- vsel  out  2  write-back mux: 00 C, 01 PC, 10 sximm8, 11 mdata
- write  out  1  register-file write enable
- loada  out  1  A register load
- loadb  out  1  B register load
- loadc  out  1  C register load
- loads  out  1  status register load
- asel  out  1  1 = ALU A input forced to 0
- bsel  out  1  1 = ALU B input from sximm5
- illegal  out  1  illegal-opcode indication (see Optional Feature)

Behaviour:
- Moore outputs, all registered state decoded combinationally. Outputs are 0 in every state unless listed below.
- Reset (async, any time, including mid-instruction) forces WAIT: w=1, all other outputs 0, illegal=0. Start-armed flag is set.
- States and per-state outputs:
  - WAIT: w=1.
  - DECODE: no asserted outputs.
  - GET_A: nsel=001, loada=1.
  - GET_B: nsel=100, loadb=1.
  - EXEC: loadc=1; asel=1 for MOV-reg and MVN, else 0; bsel=0.
  - EXEC_CMP: loads=1, asel=0.
  - WRITE_REG: nsel=010, vsel=00, write=1.
  - WRITE_IMM: nsel=001, vsel=10, write=1.
- WAIT -> DECODE when s=1 and, if START_LEVEL=1, armed. Leaving WAIT clears armed; s=0 while in WAIT sets it.
- DECODE transitions:
  - opcode=110, op=10 (MOV Rn,#imm8) -> WRITE_IMM -> WAIT. Total 3 cycles start-to-w.
  - opcode=110, op=00 (MOV Rd,Rm{,sh}) -> GET_B -> EXEC -> WRITE_REG -> WAIT.
  - opcode=101, op=00 ADD or op=10 AND -> GET_A -> GET_B -> EXEC -> WRITE_REG -> WAIT.
  - opcode=101, op=01 CMP -> GET_A -> GET_B -> EXEC_CMP -> WAIT. No register write.
  - opcode=101, op=11 MVN -> GET_B -> EXEC -> WRITE_REG -> WAIT.
  - Any other opcode/op is illegal; handled per Optional Feature.
- Internal sub-path flag latched in DECODE selects the EXEC and GET_A/GET_B successors. opcode/op are sampled only in DECODE; changes afterwards are ignored.
- s is ignored outside WAIT. s held high with START_LEVEL=0 back-to-back starts the next instruction the cycle after WAIT.
- write, loads and loadc are never asserted in the same cycle. Exactly one write pulse per writing instruction.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: illegal encoding in DECODE -> HALT state. In HALT, illegal=1, w=0, all other outputs 0. HALT is left only by reset.
- Undefined: illegal encoding in DECODE -> WAIT next cycle with no side effects; illegal tied 0; no HALT state.

Test Plan:
- Reset mid-ADD (assert in GET_B) -> same cycle w=1, loadb=0. After release, state WAIT and s=1 restarts cleanly.
- MOV R0,#7 (opcode=110, op=10), s pulse -> DECODE, then WRITE_IMM with nsel=001, vsel=10, write=1 for one cycle. w=1 on 3rd cycle after s sampled.
- ADD (101/00) -> loada@GET_A, loadb@GET_B, loadc@EXEC with asel=0, write@WRITE_REG with nsel=010. w returns after 6 cycles. Exactly one write.
- CMP (101/01) -> loads=1 for exactly one cycle, write never asserted, back to WAIT after 5 cycles.
- MVN (101/11) and MOV Rd,Rm (110/00) -> GET_A skipped. EXEC has asel=1. START_LEVEL=1 with s held high -> no second start until s low for ≥1 cycle in WAIT.
- opcode=111: with CTRL_ILLEGAL_TRAP_EN -> illegal=1, w=0 held 20 cycles until reset. Without the macro -> back in WAIT after 2 cycles, illegal=0.
